// File: rtl/csp_channel_4phase_if.sv
//------------------------------------------------------------------------------
// Module  : csp_channel_4phase_if
// Purpose : Sender/receiver 4-phase bundled-data handshake bundle for the
//           CSP rendezvous channel, plus status/counter observation signals.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface csp_channel_4phase_if #(
    parameter int WIDTH       = 64,
    parameter int COUNT_WIDTH = 16
);
    logic                   s_req;
    logic [WIDTH-1:0]       s_data;
    logic                   s_ack;
    logic                   r_req;
    logic [WIDTH-1:0]       r_data;
    logic                   r_ack;
    logic [1:0]             status;
    logic                   proto_err;
    logic [COUNT_WIDTH-1:0] xfer_count;

    // Environment side: posts requests and bundled data.
    modport master (
        output s_req, s_data, r_req,
        input  s_ack, r_data, r_ack, status, proto_err, xfer_count
    );

    // Channel side.
    modport slave (
        input  s_req, s_data, r_req,
        output s_ack, r_data, r_ack, status, proto_err, xfer_count
    );
endinterface

`default_nettype wire

// File: rtl/csp_channel_4phase.sv
//------------------------------------------------------------------------------
// Module  : csp_channel_4phase
// Purpose : Clocked CSP rendezvous channel; one transfer per both-sided 4-phase
//           request, status reporting, bundling-violation detect, transfer count.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csp_channel_4phase #(
    parameter int WIDTH       = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  wire                  clk,
    input  wire                  reset,
    csp_channel_4phase_if.slave  ch
);

    localparam logic       PH_LOW    = 1'b0;
    localparam logic       PH_HIGH   = 1'b1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND_PEND = 2'd1;
    localparam logic [1:0] ST_RECV_PEND = 2'd2;
    localparam logic [1:0] ST_BUSY      = 2'd3;

    logic                   s_ph_q,   s_ph_d;
    logic                   r_ph_q,   r_ph_d;
    logic [WIDTH-1:0]       r_data_q, r_data_d;
    logic [COUNT_WIDTH-1:0] count_q,  count_d;
    logic                   err_q,    err_d;
    logic                   hold_q,   hold_d;
    logic [WIDTH-1:0]       sdat_q,   sdat_d;
    logic                   xfer;
    logic [1:0]             status;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_ph_q   <= PH_LOW;
            r_ph_q   <= PH_LOW;
            r_data_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
            sdat_q   <= '0;
        end else begin
            s_ph_q   <= s_ph_d;
            r_ph_q   <= r_ph_d;
            r_data_q <= r_data_d;
            count_q  <= count_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
            sdat_q   <= sdat_d;
        end
    end

    always_comb begin
        xfer = ch.s_req & ch.r_req & (s_ph_q == PH_LOW) & (r_ph_q == PH_LOW);

        s_ph_d = s_ph_q;
        if (xfer)
            s_ph_d = PH_HIGH;
        else if ((s_ph_q == PH_HIGH) && !ch.s_req)
            s_ph_d = PH_LOW;

        r_ph_d = r_ph_q;
        if (xfer)
            r_ph_d = PH_HIGH;
        else if ((r_ph_q == PH_HIGH) && !ch.r_req)
            r_ph_d = PH_LOW;

        r_data_d = xfer ? ch.s_data : r_data_q;
        count_d  = count_q + {{(COUNT_WIDTH-1){1'b0}}, xfer};

        // A lone, unacknowledged send must keep its data stable across cycles.
        hold_d = ch.s_req & ~ch.r_req & (s_ph_q == PH_LOW);
        sdat_d = ch.s_data;
        err_d  = hold_q & hold_d & (ch.s_data != sdat_q);
    end

    always_comb begin
        status = ST_IDLE;
        if ((s_ph_q == PH_HIGH) || (r_ph_q == PH_HIGH))
            status = ST_BUSY;
        else if (ch.s_req && !ch.r_req)
            status = ST_SEND_PEND;
        else if (ch.r_req && !ch.s_req)
            status = ST_RECV_PEND;
    end

    assign ch.s_ack      = (s_ph_q == PH_HIGH);
    assign ch.r_ack      = (r_ph_q == PH_HIGH);
    assign ch.r_data     = r_data_q;
    assign ch.status     = status;
    assign ch.proto_err  = err_q;
    assign ch.xfer_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_csp_channel_4phase.sv
//------------------------------------------------------------------------------
// Module  : tb_csp_channel_4phase
// Purpose : Directed self-checking bench for csp_channel_4phase.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_csp_channel_4phase;

    localparam int WIDTH       = 64;
    localparam int COUNT_WIDTH = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   errs;

    csp_channel_4phase_if #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) ch ();

    csp_channel_4phase #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .ch    (ch.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_acks(input string tag, input logic sa, input logic ra);
        chk({tag, ".s_ack"}, {63'd0, ch.s_ack}, {63'd0, sa});
        chk({tag, ".r_ack"}, {63'd0, ch.r_ack}, {63'd0, ra});
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        reset     = 1'b1;
        ch.s_req  = 1'b0;
        ch.r_req  = 1'b0;
        ch.s_data = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk_acks("rst", 1'b0, 1'b0);
        chk("rst.r_data", ch.r_data, 64'd0);
        chk("rst.status", {62'd0, ch.status}, 64'd0);
        chk("rst.proto_err", {63'd0, ch.proto_err}, 64'd0);
        chk("rst.count", {60'd0, ch.xfer_count}, 64'd0);

        // 1: sender first, receiver two cycles later
        ch.s_req  = 1'b1;
        ch.s_data = 64'h0040_FFFF_1111_1111;
        tick();
        chk("t1.status_pend", {62'd0, ch.status}, 64'd1);
        chk_acks("t1.wait", 1'b0, 1'b0);
        tick();
        chk("t1.status_pend2", {62'd0, ch.status}, 64'd1);
        ch.r_req = 1'b1;
        tick();
        chk_acks("t1.xfer", 1'b1, 1'b1);
        chk("t1.r_data", ch.r_data, 64'h0040_FFFF_1111_1111);
        chk("t1.count", {60'd0, ch.xfer_count}, 64'd1);
        chk("t1.status_busy", {62'd0, ch.status}, 64'd3);
        ch.s_req = 1'b0;
        ch.r_req = 1'b0;
        tick();
        chk_acks("t1.rtz", 1'b0, 1'b0);
        chk("t1.r_data_hold", ch.r_data, 64'h0040_FFFF_1111_1111);
        chk("t1.status_idle", {62'd0, ch.status}, 64'd0);

        // 2: receiver first, type bits 00
        ch.r_req = 1'b1;
        tick();
        chk("t2.status_rpend", {62'd0, ch.status}, 64'd2);
        chk_acks("t2.wait", 1'b0, 1'b0);
        ch.s_req  = 1'b1;
        ch.s_data = 64'h0000_FFFF_1111_1111;
        tick();
        chk_acks("t2.xfer", 1'b1, 1'b1);
        chk("t2.r_data", ch.r_data, 64'h0000_FFFF_1111_1111);
        chk("t2.count", {60'd0, ch.xfer_count}, 64'd2);
        chk("t2.proto_err", {63'd0, ch.proto_err}, 64'd0);
        ch.s_req = 1'b0;
        ch.r_req = 1'b0;
        tick();

        // 3: simultaneous requests, receiver lingers in HIGH phase
        ch.s_req  = 1'b1;
        ch.r_req  = 1'b1;
        ch.s_data = 64'hC0C0_0000_0000_0003;
        tick();
        chk_acks("t3.xfer", 1'b1, 1'b1);
        chk("t3.count", {60'd0, ch.xfer_count}, 64'd3);
        ch.s_req = 1'b0;
        tick();
        chk_acks("t3.s_rtz", 1'b0, 1'b1);
        chk("t3.status_busy", {62'd0, ch.status}, 64'd3);
        ch.s_req  = 1'b1;
        ch.s_data = 64'hD0D0_0000_0000_0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_acks("t3.blocked", 1'b0, 1'b1);
            chk("t3.r_data_stable", ch.r_data, 64'hC0C0_0000_0000_0003);
        end
        ch.r_req = 1'b0;
        tick();
        chk_acks("t3.r_rtz", 1'b0, 1'b0);
        chk("t3.status_spend", {62'd0, ch.status}, 64'd1);
        chk("t3.count_hold", {60'd0, ch.xfer_count}, 64'd3);
        ch.r_req = 1'b1;
        tick();
        chk_acks("t3.xfer2", 1'b1, 1'b1);
        chk("t3.r_data2", ch.r_data, 64'hD0D0_0000_0000_0004);
        chk("t3.count2", {60'd0, ch.xfer_count}, 64'd4);

        // 4: reset mid-transfer
        reset = 1'b1;
        tick();
        chk_acks("t4.rst", 1'b0, 1'b0);
        chk("t4.r_data", ch.r_data, 64'd0);
        chk("t4.count", {60'd0, ch.xfer_count}, 64'd0);
        chk("t4.status", {62'd0, ch.status}, 64'd0);
        ch.s_req = 1'b0;
        ch.r_req = 1'b0;
        tick();
        reset = 1'b0;

        // 5: bundling violation, then withdrawal
        ch.s_req  = 1'b1;
        ch.s_data = 64'h1111_2222_3333_4444;
        tick();
        tick();
        chk("t5.no_err", {63'd0, ch.proto_err}, 64'd0);
        ch.s_data = 64'h5555_6666_7777_8888;
        tick();
        chk("t5.err_pulse", {63'd0, ch.proto_err}, 64'd1);
        tick();
        chk("t5.err_clear", {63'd0, ch.proto_err}, 64'd0);
        ch.s_req = 1'b0;
        tick();
        chk_acks("t5.withdraw", 1'b0, 1'b0);
        chk("t5.count", {60'd0, ch.xfer_count}, 64'd0);
        chk("t5.status", {62'd0, ch.status}, 64'd0);

        // 6: 16 transfers wrap the 4-bit counter
        for (int i = 1; i <= 16; i++) begin
            ch.s_req  = 1'b1;
            ch.r_req  = 1'b1;
            ch.s_data = 64'(i);
            tick();
            ch.s_req = 1'b0;
            ch.r_req = 1'b0;
            tick();
            if (i == 15)
                chk("t6.count15", {60'd0, ch.xfer_count}, 64'd15);
        end
        chk("t6.wrap", {60'd0, ch.xfer_count}, 64'd0);
        chk("t6.r_data", ch.r_data, 64'd16);
        chk_acks("t6.idle", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

`default_nettype wire
